// File: rtl/snx_if.sv
// Bus bundle between the snx core and its instruction and data/IO memories.
interface snx_if;
    logic [31:0] inst;
    logic [15:0] datai;
    logic [15:0] datao;
    logic [15:0] iadrs;
    logic [15:0] adrs;
    logic        inst_read;
    logic        inst_write;
    logic        memory_read;
    logic        memory_write;
    logic        wb;
    logic        hlt;

    modport master (
        input  inst, datai,
        output datao, iadrs, adrs, inst_read, inst_write,
               memory_read, memory_write, wb, hlt
    );

    modport slave (
        output inst, datai,
        input  datao, iadrs, adrs, inst_read, inst_write,
               memory_read, memory_write, wb, hlt
    );
endinterface

// File: rtl/snx.sv
// 16-bit SN/X-style core: fetches an instruction pair, executes slot A and,
// when independent, slot B in the same EXEC cycle.
module snx (
    input  logic   m_clock,
    input  logic   p_reset,
    snx_if.master  bus
);

    typedef enum logic [1:0] {FETCH, EXEC, HALT} state_t;

    typedef struct packed {
        logic [3:0]  op;
        logic [1:0]  r3;
        logic [1:0]  r2;
        logic [15:0] imm;
        logic        wr;
        logic [1:0]  wd;
    } slot_t;

    function automatic slot_t decode(input logic [15:0] w);
        slot_t s;
        s.op  = w[15:12];
        s.r3  = w[11:10];
        s.r2  = w[9:8];
        s.imm = {{8{w[7]}}, w[7:0]};
        s.wr  = 1'b0;
        s.wd  = w[7:6];
        case (w[15:12])
            4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h6: s.wr = 1'b1;
            4'h8, 4'ha, 4'hf: begin
                s.wr = 1'b1;
                s.wd = w[9:8];
            end
            default: ;
        endcase
        return s;
    endfunction

    function automatic logic reads_r2(input logic [3:0] op);
        return op inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h6, 4'h9, 4'he};
    endfunction

    function automatic logic reads_r3(input logic [3:0] op);
        return op inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h8, 4'h9, 4'ha, 4'he, 4'hf};
    endfunction

    function automatic logic [15:0] result(input slot_t s, input logic [15:0] v2,
                                           input logic [15:0] v3, input logic [15:0] spc,
                                           input logic [15:0] din);
        case (s.op)
            4'h0:    return v2 + v3;
            4'h1:    return v2 & v3;
            4'h2:    return v2 - v3;
            4'h3:    return ($signed(v2) < $signed(v3)) ? 16'h0001 : 16'h0000;
            4'h4:    return ~v2;
            4'h6:    return {1'b0, v2[15:1]};
            4'h8:    return din;
            4'ha:    return v3 + s.imm;
            4'hf:    return spc + 16'h0001;
            default: return '0;
        endcase
    endfunction

    state_t      state;
    logic [15:0] pc;
    logic [31:0] ir;
    logic [15:0] regs [4];
    logic        halted;

    slot_t       sa, sb, sm;
    logic [15:0] a_v2, a_v3, b_v2, b_v3, m_v2, m_v3;
    logic [15:0] a_res, b_res, a_tgt, b_tgt, pc_next, m_addr;
    logic        a_pairable, dual, a_br, b_br, a_halt, b_halt;
    logic        exec, m_ld, m_st, wr_any;

    always_comb begin
        sa   = decode(pc[0] ? ir[15:0] : ir[31:16]);
        sb   = decode(ir[15:0]);
        a_v2 = regs[sa.r2];
        a_v3 = regs[sa.r3];
        b_v2 = regs[sb.r2];
        b_v3 = regs[sb.r3];

        // B may pair only if it neither reads nor overwrites A's destination.
        a_pairable = !(sa.op inside {4'h7, 4'h8, 4'h9, 4'he, 4'hf});
        dual = !pc[0] && a_pairable &&
               !(sa.wr && ((reads_r2(sb.op) && sb.r2 == sa.wd) ||
                           (reads_r3(sb.op) && sb.r3 == sa.wd) ||
                           (sb.wr && sb.wd == sa.wd)));

        sm     = dual ? sb : sa;
        m_v2   = dual ? b_v2 : a_v2;
        m_v3   = dual ? b_v3 : a_v3;
        m_addr = m_v3 + sm.imm;
        exec   = (state == EXEC);
        m_ld   = exec && sm.op == 4'h8;
        m_st   = exec && sm.op == 4'h9;

        a_res = result(sa, a_v2, a_v3, pc, bus.datai);
        b_res = result(sb, b_v2, b_v3, pc + 16'h0001, bus.datai);
        a_tgt = a_v3 + sa.imm;
        b_tgt = b_v3 + sb.imm;
        a_br  = (sa.op == 4'he && a_v2 == '0) || sa.op == 4'hf;
        b_br  = dual && ((sb.op == 4'he && b_v2 == '0) || sb.op == 4'hf);
        a_halt = sa.op == 4'h7;
        b_halt = dual && sb.op == 4'h7;
        wr_any = exec && (sa.wr || (dual && sb.wr));

        if (a_br)
            pc_next = a_tgt;
        else if (b_br)
            pc_next = b_tgt;
        else if (dual)
            pc_next = pc + 16'h0002;
        else
            pc_next = pc + 16'h0001;
    end

    always_ff @(posedge m_clock or posedge p_reset) begin
        if (p_reset) begin
            state  <= FETCH;
            pc     <= '0;
            ir     <= '0;
            halted <= 1'b0;
            for (int unsigned i = 0; i < 4; i++)
                regs[i] <= '0;
        end else begin
            case (state)
                FETCH: begin
                    ir    <= bus.inst;
                    state <= EXEC;
                end
                EXEC: begin
                    if (sa.wr)
                        regs[sa.wd] <= a_res;
                    if (dual && sb.wr)
                        regs[sb.wd] <= b_res;
                    if (a_halt || b_halt) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end else begin
                        pc    <= pc_next;
                        state <= FETCH;
                    end
                end
                HALT: ;
                default: state <= FETCH;
            endcase
        end
    end

    // Strobes are gated by reset so they drop the moment reset is asserted.
    assign bus.iadrs        = pc;
    assign bus.inst_read    = (state == FETCH) && !p_reset;
    assign bus.inst_write   = 1'b0;
    assign bus.memory_read  = m_ld && !p_reset;
    assign bus.memory_write = m_st && !p_reset;
    assign bus.wb           = wr_any && !p_reset;
    assign bus.adrs         = (m_ld || m_st) ? m_addr : '0;
    assign bus.datao        = m_st ? m_v2 : '0;
    assign bus.hlt          = halted;

endmodule

// File: tb/tb_snx.sv
// Directed bench for snx: small programs with hand-computed register,
// PC, strobe and memory results.
module tb_snx;

    logic        m_clock = 1'b0;
    logic        p_reset = 1'b1;
    logic [15:0] imem   [64];
    logic [15:0] dmem   [64];
    logic [15:0] st_mem [64];
    logic [15:0] io_sw = 16'h0034;
    int unsigned n_pass  = 0;
    int unsigned n_total = 0;
    int unsigned fetches;

    snx_if bus ();

    snx dut (
        .m_clock (m_clock),
        .p_reset (p_reset),
        .bus     (bus)
    );

    always #5 m_clock = ~m_clock;

    assign bus.inst  = {imem[{bus.iadrs[5:1], 1'b0}], imem[{bus.iadrs[5:1], 1'b1}]};
    assign bus.datai = bus.adrs[15] ? io_sw : dmem[bus.adrs[5:0]];

    always @(posedge m_clock)
        if (bus.memory_write && !bus.adrs[15])
            st_mem[bus.adrs[5:0]] <= bus.datao;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic begin_test();
        p_reset = 1'b1;
        #1;
        for (int i = 0; i < 64; i++) begin
            imem[i] = 16'h5000;
            dmem[i] = '0;
        end
    endtask

    task automatic release_reset();
        @(negedge m_clock);
        p_reset = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge m_clock);
        #1;
    endtask

    task automatic run_to_halt(input string tag);
        for (int i = 0; i < 300 && !bus.hlt; i++)
            step(1);
        check(tag, bus.hlt, 1'b1);
    endtask

    initial begin
        // Dual issue of two independent lda; reset state observed first.
        begin_test();
        imem[0] = 16'ha105;
        imem[1] = 16'ha2fd;
        imem[2] = 16'h7000;
        @(negedge m_clock);
        check("rst_iadrs", bus.iadrs, 16'h0000);
        check("rst_strobes", {bus.inst_read, bus.memory_read, bus.memory_write, bus.wb}, 4'b0000);
        check("rst_hlt", bus.hlt, 1'b0);
        check("rst_adrs_datao", {bus.adrs, bus.datao}, 32'h0);
        release_reset();
        #1;
        check("fetch_strobe", {bus.inst_read, bus.iadrs}, {1'b1, 16'h0000});
        step(1);
        check("dual_wb", {bus.wb, bus.inst_read}, 2'b10);
        step(1);
        check("dual_r1", dut.regs[1], 16'h0005);
        check("dual_r2", dut.regs[2], 16'hfffd);
        check("dual_pc", dut.pc, 16'h0002);
        run_to_halt("dual_halt");

        // RAW hazard splits the pair.
        begin_test();
        imem[0] = 16'ha101;
        imem[1] = 16'h0580;
        imem[2] = 16'h7000;
        release_reset();
        step(2);
        check("raw_pc_single", dut.pc, 16'h0001);
        step(2);
        check("raw_r2", dut.regs[2], 16'h0002);
        check("raw_pc", dut.pc, 16'h0002);
        run_to_halt("raw_halt");

        // IO load and store at 0x8000.
        begin_test();
        imem[0] = 16'h40c0;
        imem[1] = 16'h63c0;
        imem[2] = 16'h43c0;
        imem[3] = 16'h8d00;
        imem[4] = 16'h9d00;
        imem[5] = 16'h7000;
        release_reset();
        step(7);
        check("ld_strobe", {bus.memory_read, bus.memory_write, bus.wb}, 3'b101);
        check("ld_adrs", bus.adrs, 16'h8000);
        step(1);
        check("ld_r1", dut.regs[1], 16'h0034);
        check("ld_strobe_off", bus.memory_read, 1'b0);
        step(1);
        check("st_strobe", {bus.memory_read, bus.memory_write, bus.wb}, 3'b010);
        check("st_adrs_datao", {bus.adrs, bus.datao}, {16'h8000, 16'h0034});
        run_to_halt("io_halt");

        // bz taken / not taken, bal at odd PC.
        begin_test();
        imem[0]  = 16'he006;
        imem[6]  = 16'ha101;
        imem[7]  = 16'he102;
        imem[8]  = 16'he003;
        imem[3]  = 16'hf30a;
        imem[10] = 16'h7000;
        release_reset();
        step(2);
        check("bz_taken_pc", dut.pc, 16'h0006);
        step(4);
        check("bz_not_taken_pc", dut.pc, 16'h0008);
        step(2);
        check("bz_to_odd_iadrs", {bus.inst_read, bus.iadrs}, {1'b1, 16'h0003});
        step(2);
        check("bal_pc", dut.pc, 16'h000a);
        check("bal_link", dut.regs[3], 16'h0004);
        run_to_halt("br_halt");

        // ALU corner cases, observed through stores to data memory.
        begin_test();
        imem[0]  = 16'ha2ff;
        imem[1]  = 16'ha301;
        imem[2]  = 16'h3e40;
        imem[3]  = 16'h5000;
        imem[4]  = 16'h9100;
        imem[5]  = 16'h4000;
        imem[6]  = 16'h6000;
        imem[7]  = 16'h4000;
        imem[8]  = 16'h0c00;
        imem[9]  = 16'h6040;
        imem[10] = 16'h9d02;
        imem[11] = 16'h8e07;
        imem[12] = 16'h4240;
        imem[13] = 16'h9d03;
        imem[14] = 16'hacff;
        imem[15] = 16'h2c40;
        imem[16] = 16'h9d04;
        imem[17] = 16'h7000;
        dmem[8]  = 16'h00ff;
        release_reset();
        run_to_halt("alu_halt");
        check("slt_signed", st_mem[0], 16'h0001);
        check("sr_logical", st_mem[3], 16'h4000);
        check("not_00ff", st_mem[4], 16'hff00);
        check("sub_wrap", st_mem[5], 16'hffff);

        // hlt in slot B at an odd address; older slot A still completes.
        begin_test();
        imem[0] = 16'ha107;
        imem[1] = 16'h7000;
        release_reset();
        step(2);
        check("hltb_hlt", bus.hlt, 1'b1);
        check("hltb_r1", dut.regs[1], 16'h0007);
        fetches = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (bus.inst_read || !bus.hlt)
                fetches++;
        end
        check("halt_held_no_fetch", fetches, 0);

        // Asynchronous reset in the middle of a load loop.
        begin_test();
        imem[0] = 16'h8100;
        imem[1] = 16'he000;
        dmem[0] = 16'h1234;
        release_reset();
        step(5);
        check("loop_ld_active", bus.memory_read, 1'b1);
        check("loop_r1", dut.regs[1], 16'h1234);
        #2 p_reset = 1'b1;
        #1;
        check("mid_rst_strobes", {bus.memory_read, bus.inst_read, bus.hlt}, 3'b000);
        check("mid_rst_pc", {dut.pc, bus.adrs}, 32'h0);
        check("mid_rst_r1", dut.regs[1], 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/snx.md
Name: snx

Overview:
- 16-bit SN/X-style processor core with four 16-bit general registers and a 16-instruction ISA.
- Fetches a 32-bit instruction pair and issues up to two instructions per execute cycle.
- Sits between a word-addressed instruction memory and a data/IO memory. Both memories drive their read data on the falling clock edge while the matching read strobe is high.

Parameters:
- none

Ports:
- m_clock  in  1  clock; all state updates on rising edge
- p_reset  in  1  reset, asynchronous, active-high
- inst  in  32  instruction pair: [31:16]=word at (iadrs&~1), [15:0]=word at (iadrs|1); valid at the rising edge ending an inst_read cycle
- datai  in  16  data read; valid at the rising edge ending a memory_read cycle
- datao  out  16  store data
- iadrs  out  16  instruction word address (PC)
- adrs  out  16  data word address; bit15=1 selects IO (external decode)
- inst_read  out  1  instruction fetch strobe
- inst_write  out  1  constant 0
- memory_read  out  1  load strobe
- memory_write  out  1  store strobe
- wb  out  1  register write-back occurs at the end of this cycle
- hlt  out  1  core halted

Behaviour:
- Encoding: op=[15:12], r3=[11:10], r2=[9:8], r1=[7:6], I=[7:0] (sign-extended to 16 bits, written sext(I)). I-type ignores r1.
- Opcodes:
  - 0 add: r1=r2+r3
  - 1 and: r1=r2&r3
  - 2 sub: r1=r2-r3
  - 3 slt: r1=(signed r2<r3)?1:0
  - 4 not: r1=~r2
  - 6 sr: r1=r2>>1, logical
  - 7 hlt
  - 8 ld: r2=M[r3+sext(I)]
  - 9 st: M[r3+sext(I)]=r2
  - a lda: r2=r3+sext(I)
  - e bz: if r2==0, PC=r3+sext(I)
  - f bal: r2=PC+1, PC=r3+sext(I)
  - 5, b, c, d: no-op
- Arithmetic: all modulo 2^16. Registers $0..$3 are all ordinary read/write registers.
- Reset: PC=0, registers=0, state=FETCH, hlt=0, all strobes 0, datao/adrs/iadrs=0.
- State FETCH: iadrs=PC, inst_read=1. The pair is latched at the rising edge; next state EXEC.
- State EXEC, slot A:
  - Slot A is the instruction at word PC: high half of the pair if PC is even, low half if PC is odd.
  - Slot A always executes.
- State EXEC, slot B (dual issue):
  - Slot B is the low half and executes in the same cycle only if all of these hold:
    - PC is even;
    - A is one of add/and/sub/slt/not/sr/lda/no-op;
    - no source register of B (r2, r3 as used) equals A's destination;
    - B's destination differs from A's destination.
  - Otherwise B is refetched as the next slot A.
  - B reads pre-cycle register values.
- PC update in EXEC:
  - taken branch or bal: target;
  - else PC+2 if dual-issued;
  - else PC+1.
  - For bal, the link value is the address of the bal itself +1.
- Memory: only one ld/st per cycle.
  - ld: adrs=address, memory_read=1 for the EXEC cycle; register takes datai at the ending edge.
  - st: adrs=address, datao=r2, memory_write=1 for one cycle.
- wb=1 in any EXEC cycle in which at least one register is written. Up to two registers are written at the same edge.
- hlt executed in either slot:
  - an older dual-issued slot-A instruction in the same cycle still completes;
  - next state HALT.
- HALT: hlt=1 held, all strobes 0, no state change until reset.
- Reset asserted mid-operation forces the reset state immediately. Any strobe in progress drops asynchronously.
- Strobes are 0 in every cycle not listed above.

Test Plan:
- Reset, then pair {lda $1,5($0); lda $2,-3($0)} at address 0 -> dual issue in one EXEC cycle; $1=0005, $2=fffd; PC=2; wb=1.
- {lda $1,1($0); add $2,$1,$1} -> RAW dependency blocks dual issue; add executes in the next EXEC cycle; $2=0002; total 4 cycles.
- sw=0x34 at IO: ld $1,0($3) with $3=8000 -> adrs=8000, memory_read=1; $1=0034. Then st $1,0($3) -> memory_write=1, datao=0034.
- bz $0,6($0) with $0=0 -> PC=6; bz with a nonzero register -> PC+1. bal $3,10($0) at PC=3 -> $3=0004, PC=10.
- slt $1,$2,$3 with $2=ffff, $3=0001 -> $1=1; sr of 8001 -> 4000; not 00ff -> ff00; sub 0000-0001 -> ffff.
- hlt at odd address after an ALU op -> hlt=1 held forever, no further inst_read; asserting p_reset mid-program -> PC=0, registers=0 immediately.
